data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/mem_array.sv | 47 ++++
 rtl/data_mem_responder.sv | 131 +++++++++++++
 tb/tb_data_mem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the data-memory responder: FSM states, access
// encodings and the default storage depth.
package cpu_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;

  localparam int MEM_DEPTH_DEF = 256;

  // Byte loads land in the low byte with the upper bits cleared.
  function automatic logic [31:0] zext_byte(input logic [7:0] b);
    return {24'h0, b};
  endfunction
endpackage

// File: rtl/mem_array.sv
// Byte-addressed storage with a big-endian word/byte read port and a
// word/byte write port. Storage has no reset; contents are preloaded
// externally through Mem.
module mem_array import cpu_pkg::*; #(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        i_we,
  input  logic        i_size,
  input  logic [7:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata
);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [7:0]    Mem [MEM_DEPTH];
  logic [AW-1:0] w_idx [4];

  // Byte lane k of a word lives at addr+k (8-bit address wraps).
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_idx[k] = AW'(i_addr + 8'(k));
    end
  end

  // Big-endian read: the lowest address supplies the most significant byte.
  always_comb begin
    o_rdata = zext_byte(Mem[w_idx[0]]);
    if (i_size == SIZE_WORD) begin
      o_rdata = {Mem[w_idx[0]], Mem[w_idx[1]], Mem[w_idx[2]], Mem[w_idx[3]]};
    end
  end

  // Store path: full word big-endian, or the low data byte for byte stores.
  always_ff @(posedge clk) begin
    if (i_we) begin
      if (i_size == SIZE_WORD) begin
        Mem[w_idx[0]] <= i_wdata[31:24];
        Mem[w_idx[1]] <= i_wdata[23:16];
        Mem[w_idx[2]] <= i_wdata[15:8];
        Mem[w_idx[3]] <= i_wdata[7:0];
      end else begin
        Mem[w_idx[0]] <= i_wdata[7:0];
      end
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: accepts one request in IDLE, waits
// WAIT_CYCLES cycles while stalling the pipeline, then strobes ready for a
// single cycle with registered load data.
// Optional macro MISALIGN_TRAP_EN: misaligned word accesses are trapped
// (no write, rdata=0, err with ready) instead of being force-aligned.
module data_mem_responder import cpu_pkg::*; #(
  parameter int WAIT_CYCLES = 2,
  parameter int MEM_DEPTH   = MEM_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        R,
  input  logic        en,
  input  logic        rw,
  input  logic        size,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        err
`endif
);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_rw, r_size;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_rw, w_size;
  logic [7:0]  w_addr, w_addr_al;
  logic [31:0] w_wdata, w_mem_rdata, w_load;
  logic        w_resp_entry, w_we;

  // The request seen by storage: live inputs in IDLE (needed when
  // WAIT_CYCLES=0 enters RESP on the accept edge), captured copy otherwise.
  always_comb begin
    w_rw    = r_rw;
    w_size  = r_size;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    if (r_state == IDLE) begin
      w_rw    = rw;
      w_size  = size;
      w_addr  = addr;
      w_wdata = wdata;
    end
  end

  assign w_resp_entry = R && (r_state != RESP) && (w_state_nxt == RESP);

`ifdef MISALIGN_TRAP_EN
  logic w_mis, r_err;
  assign w_mis     = (w_size == SIZE_WORD) && (w_addr[1:0] != 2'b00);
  assign w_addr_al = w_addr;
  assign w_we      = w_resp_entry && (w_rw == RW_WRITE) && !w_mis;
  assign w_load    = w_mis ? 32'h0 : w_mem_rdata;
  assign err       = (r_state == RESP) && r_err;

  // Misalignment flag travels with the request into RESP.
  always_ff @(posedge clk or negedge R) begin
    if (!R)                r_err <= 1'b0;
    else if (w_resp_entry) r_err <= w_mis;
  end
`else
  assign w_addr_al = (w_size == SIZE_WORD) ? {w_addr[7:2], 2'b00} : w_addr;
  assign w_we      = w_resp_entry && (w_rw == RW_WRITE);
  assign w_load    = w_mem_rdata;
`endif

  mem_array #(.MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_size  (w_size),
    .i_addr  (w_addr_al),
    .i_wdata (w_wdata),
    .o_rdata (w_mem_rdata)
  );

  // Next-state, counter and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_cnt_nxt   = WAIT_LD;
          w_state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Reset gating keeps stall low while R is asserted even with en high.
    stall = R && (((r_state == IDLE) && en) || (r_state == WAIT));
    ready = (r_state == RESP);
  end

  // State, counter, request capture and load data register.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rw    <= RW_READ;
      r_size  <= SIZE_BYTE;
      r_addr  <= 8'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if ((r_state == IDLE) && en) begin
        r_rw    <= rw;
        r_size  <= size;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      if (w_resp_entry && (w_rw == RW_READ)) r_rdata <= w_load;
    end
  end

  assign rdata = r_rdata;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance driven by
// a vector table plus hand-written sequences, and a WAIT_CYCLES=0 instance.
module tb_data_mem_responder;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        R, en, en0, rw, size;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata, rdata0;
  logic        ready, ready0, stall, stall0;
`ifdef MISALIGN_TRAP_EN
  logic        err, err0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.WAIT_CYCLES(2), .MEM_DEPTH(256)) dut (
    .clk(clk), .R(R), .en(en), .rw(rw), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .stall(stall)
`ifdef MISALIGN_TRAP_EN
    , .err(err)
`endif
  );

  data_mem_responder #(.WAIT_CYCLES(0), .MEM_DEPTH(256)) dut0 (
    .clk(clk), .R(R), .en(en0), .rw(rw), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata0), .ready(ready0), .stall(stall0)
`ifdef MISALIGN_TRAP_EN
    , .err(err0)
`endif
  );

  typedef struct {
    string       name;
    logic        rw;
    logic        size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance; request inputs are
  // scrambled during WAIT to show they are ignored.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    en = 1'b1; rw = v.rw; size = v.size; addr = v.addr; wdata = v.wdata;
    #1 chk({v.name, " stall_accept"}, 32'(stall), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      en = 1'b1; rw = ~v.rw; addr = ~v.addr; wdata = 32'h0BAD0BAD;
      #1;
      chk({v.name, " stall_wait"}, 32'(stall), 32'd1);
      chk({v.name, " ready_wait"}, 32'(ready), 32'd0);
    end
    @(negedge clk);
    en = 1'b0;
    #1;
    chk({v.name, " ready_resp"}, 32'(ready), 32'd1);
    chk({v.name, " stall_resp"}, 32'(stall), 32'd0);
    chk({v.name, " rdata"}, rdata, v.exp_rdata);
`ifdef MISALIGN_TRAP_EN
    chk({v.name, " err"}, 32'(err), 32'(v.exp_err));
`endif
    @(negedge clk);
    #1 chk({v.name, " ready_idle"}, 32'(ready), 32'd0);
  endtask

  initial begin
    int readies;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    // name, rw, size, addr, wdata, expected rdata, expected err
    // Preload: Mem[i]=i, then Mem[0..3]=DE AD BE EF.
    vecs[0]  = '{"rdW00",   RW_READ,  SIZE_WORD, 8'h00, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1]  = '{"wrB11",   RW_WRITE, SIZE_BYTE, 8'h11, 32'hFFFFFF5A, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{"rdB11",   RW_READ,  SIZE_BYTE, 8'h11, 32'h0,        32'h0000005A, 1'b0};
    vecs[3]  = '{"rdW10",   RW_READ,  SIZE_WORD, 8'h10, 32'h0,        32'h105A1213, 1'b0};
    vecs[4]  = '{"wrW40",   RW_WRITE, SIZE_WORD, 8'h40, 32'hCAFEF00D, 32'h105A1213, 1'b0};
    vecs[5]  = '{"rdW40",   RW_READ,  SIZE_WORD, 8'h40, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[6]  = '{"rdB42",   RW_READ,  SIZE_BYTE, 8'h42, 32'h0,        32'h000000F0, 1'b0};
    vecs[7]  = '{"rdB03",   RW_READ,  SIZE_BYTE, 8'h03, 32'h0,        32'h000000EF, 1'b0};
    vecs[8]  = '{"rdBFF",   RW_READ,  SIZE_BYTE, 8'hFF, 32'h0,        32'h000000FF, 1'b0};
    vecs[9]  = '{"rdW02",   RW_READ,  SIZE_WORD, 8'h02, 32'h0,
                 TRAP ? 32'h0 : 32'hDEADBEEF, TRAP};
    vecs[10] = '{"wrW06",   RW_WRITE, SIZE_WORD, 8'h06, 32'h11223344,
                 TRAP ? 32'h0 : 32'hDEADBEEF, TRAP};
    vecs[11] = '{"rdW04",   RW_READ,  SIZE_WORD, 8'h04, 32'h0,
                 TRAP ? 32'h04050607 : 32'h11223344, 1'b0};

    R = 1'b1; en = 1'b1; en0 = 1'b1; rw = RW_READ; size = SIZE_WORD;
    addr = 8'h00; wdata = 32'h0;
    #2 R = 1'b0;
    for (int i = 0; i < 256; i++) begin
      dut.u_mem.Mem[i]  = 8'(i);
      dut0.u_mem.Mem[i] = 8'(i);
    end
    dut.u_mem.Mem[0]  = 8'hDE; dut.u_mem.Mem[1]  = 8'hAD;
    dut.u_mem.Mem[2]  = 8'hBE; dut.u_mem.Mem[3]  = 8'hEF;
    dut0.u_mem.Mem[0] = 8'hDE; dut0.u_mem.Mem[1] = 8'hAD;
    dut0.u_mem.Mem[2] = 8'hBE; dut0.u_mem.Mem[3] = 8'hEF;

    // Reset state with en held high.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    chk("rst_stall0", 32'(stall0), 32'd0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    @(negedge clk);
    en = 1'b0; en0 = 1'b0; R = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // en held high for 20 cycles: one response per 4 cycles, and only the
    // address presented in the accept cycle matters.
    readies = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      en = 1'b1; rw = RW_READ; size = SIZE_WORD;
      addr = ((c % 4) == 0) ? 8'h00 : 8'h10;
      #1;
      if (ready) readies++;
      chk($sformatf("cont_stall c%0d", c), 32'(stall), ((c % 4) == 3) ? 32'd0 : 32'd1);
      if ((c % 4) == 3) chk($sformatf("cont_rdata c%0d", c), rdata, 32'hDEADBEEF);
    end
    chk("cont_ready_count", 32'(readies), 32'd5);
    @(negedge clk);
    en = 1'b0;

    // Reset during WAIT of a word write: nothing stored, outputs quiet.
    @(negedge clk);
    en = 1'b1; rw = RW_WRITE; size = SIZE_WORD; addr = 8'h20; wdata = 32'h12345678;
    @(negedge clk);
    en = 1'b0;
    #1 chk("rstw_in_wait", 32'(dut.r_state), 32'(WAIT));
    R = 1'b0;
    #1;
    chk("rstw_state", 32'(dut.r_state), 32'(IDLE));
    chk("rstw_stall", 32'(stall), 32'd0);
    chk("rstw_ready", 32'(ready), 32'd0);
    @(negedge clk);
    en = 1'b1;
    #1 chk("rstw_stall_en", 32'(stall), 32'd0);
    @(negedge clk);
    en = 1'b0; R = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstw_mem", {dut.u_mem.Mem[32], dut.u_mem.Mem[33], dut.u_mem.Mem[34],
                     dut.u_mem.Mem[35]}, 32'h20212223);
    run_vec('{"post_rst_rdW20", RW_READ, SIZE_WORD, 8'h20, 32'h0, 32'h20212223, 1'b0});

    // WAIT_CYCLES=0 instance: stall only in the accept cycle, ready next.
    @(negedge clk);
    en0 = 1'b1; rw = RW_READ; size = SIZE_WORD; addr = 8'h00;
    #1;
    chk("w0_stall_acc", 32'(stall0), 32'd1);
    chk("w0_ready_acc", 32'(ready0), 32'd0);
    @(negedge clk);
    en0 = 1'b0;
    #1;
    chk("w0_ready", 32'(ready0), 32'd1);
    chk("w0_stall_resp", 32'(stall0), 32'd0);
    chk("w0_rdata", rdata0, 32'hDEADBEEF);
    @(negedge clk);
    #1;
    chk("w0_ready_idle", 32'(ready0), 32'd0);
    chk("w0_stall_idle", 32'(stall0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
